pool_upsample_2x: RTL

- Streaming 2x nearest-neighbour upsampler for 4-bit single-channel pixels; the inverse of the 2x2 pooling filter.
- Takes a raster stream of a W2 x H2 pooled image and emits a 2*W2 x 2*H2 raster stream.
- Each input pixel becomes a 2x2 block of identical output pixels.
- A one-row line buffer replays each input row for the odd output rows; valid/ready handshakes on both sides.

---
 rtl/pool_upsample_2x.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pool_upsample_2x.sv
// ---------------------------------------------------------------------------
// pool_upsample_2x
//   Streaming 2x nearest-neighbour upsampler for 4-bit pixels. A W2 x H2
//   raster input becomes a 2*W2 x 2*H2 raster output: each pixel is sent
//   twice on the even output row, then replayed twice on the odd output row
//   from a one-row line buffer.
//
//   Optional build macro: UPS_PACK_EN
//     defined   : out_data is 8 bits {p,p}, one beat per pixel per output row
//     undefined : out_data is 4 bits, two beats per pixel per output row
//
//   States:
//     S_PASS | even output row, pixels come from the input port
//     S_REPL | odd output row, pixels are replayed from the line buffer
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake, in_data = 4-bit pixel
//   out_valid/out_ready   output handshake, out_data = pixel (or packed pair)
//   out_eol               beat is the last of an output row
//   out_eof               beat is the last of the output frame
// ---------------------------------------------------------------------------
module pool_upsample_2x #(
    parameter int W2 = 90,
    parameter int H2 = 90,
    parameter int CW = 7,
    parameter int RW = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef UPS_PACK_EN
    output logic [7:0] out_data,
`else
    output logic [3:0] out_data,
`endif
    output logic       out_eol,
    output logic       out_eof
);

    typedef enum logic {S_PASS = 1'b0, S_REPL = 1'b1} state_t;

    localparam logic [CW-1:0] LAST_COL = CW'(W2 - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(H2 - 1);

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_active;
    logic          r_out_valid;
    logic          r_out_eol;
    logic          r_out_eof;
    logic [3:0]    r_linebuf [W2];
`ifdef UPS_PACK_EN
    logic [7:0]    r_out_data;
`else
    logic [3:0]    r_out_data;
    logic          r_rep;
`endif

    logic          w_rep;
    logic          w_hs;
    logic          w_adv;
    logic          w_last_col;
    logic [CW-1:0] w_col_next;
    logic [CW-1:0] w_ld_col;
    logic          w_in_ready;
    logic          w_take;
    logic          w_repl_ld;
    logic          w_ld;
    logic [3:0]    w_ld_data;

`ifdef UPS_PACK_EN
    assign w_rep = 1'b1;
`else
    assign w_rep = r_rep;
`endif

    // w_adv: the output register finishes its current pixel this cycle
    assign w_hs       = r_out_valid && out_ready;
    assign w_adv      = w_hs && w_rep;
    assign w_last_col = (r_col == LAST_COL);
    assign w_col_next = w_last_col ? '0 : r_col + 1'b1;
    // column of the pixel that would be loaded this cycle
    assign w_ld_col   = r_out_valid ? w_col_next : r_col;

    // New pixels are taken whenever the output register is about to be
    // free, except at the end of an even row (the replay row follows).
    // The final replay beat of a row already makes room for the next
    // input pixel so a held input stream runs without output bubbles.
    assign w_in_ready = r_active &&
                        (((r_state == S_PASS) && (!r_out_valid || (w_adv && !w_last_col))) ||
                         ((r_state == S_REPL) && w_adv && w_last_col));
    assign w_take     = in_valid && w_in_ready;
    assign w_repl_ld  = w_adv && ((r_state == S_PASS) ? w_last_col : !w_last_col);
    assign w_ld       = w_take || w_repl_ld;
    assign w_ld_data  = w_take ? in_data : r_linebuf[w_ld_col];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PASS;
            r_col       <= '0;
            r_row       <= '0;
            r_active    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
`ifndef UPS_PACK_EN
            r_rep       <= 1'b0;
`endif
        end else begin
            r_active <= 1'b1;
            if (w_adv) begin
                r_col <= w_col_next;
                if (w_last_col) begin
                    if (r_state == S_PASS) begin
                        r_state <= S_REPL;
                    end else begin
                        r_state <= S_PASS;
                        r_row   <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
                    end
                end
            end
            if (w_ld) begin
                r_out_valid <= 1'b1;
`ifdef UPS_PACK_EN
                r_out_data  <= {w_ld_data, w_ld_data};
                r_out_eol   <= (w_ld_col == LAST_COL);
                r_out_eof   <= w_repl_ld && (w_ld_col == LAST_COL) && (r_row == LAST_ROW);
`else
                r_out_data  <= w_ld_data;
                r_rep       <= 1'b0;
                r_out_eol   <= 1'b0;
                r_out_eof   <= 1'b0;
`endif
            end else if (w_adv) begin
                r_out_valid <= 1'b0;
            end
`ifndef UPS_PACK_EN
            else if (w_hs && !r_rep) begin
                // second copy of the same pixel; flags mark its row/frame end
                r_rep     <= 1'b1;
                r_out_eol <= w_last_col;
                r_out_eof <= w_last_col && (r_state == S_REPL) && (r_row == LAST_ROW);
            end
`endif
        end
    end

    // line buffer is storage only; its contents need no reset
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_linebuf[w_ld_col] <= in_data;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;

endmodule
